// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/bubble sequencer for the 5-stage RV32 pipeline. It covers three cases:
//   - a forced flush after reset,
//   - the load-use interlock,
//   - data-memory wait states, with a timeout into a sticky error state.
//   It also keeps saturating stall and branch-flush counters.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   rs1_id, rs2_id                   source registers of the ID instruction
//   rs1_used_id, rs2_used_id         source actually read by the ID instruction
//   rd_ex, mem_read_ex               destination / load flag of the EX instruction
//   branch_taken_ex                  EX resolved a taken branch or jump
//   mem_req_mem, dmem_ready          MEM-stage dmem access and completion
//   stall_if                         hold PC
//   stall_id/ex/mem/wb               hold the named pipe register
//   bubble_id/ex/mem/wb              load NOP into the named pipe register
//   mem_timeout                      sticky dmem timeout flag
//   stall_cnt, flush_cnt             saturating performance counters
module pipe_hazard_ctrl #(
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             branch_taken_ex,
    input  logic             mem_req_mem,
    input  logic             dmem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             stall_wb,
    output logic             bubble_id,
    output logic             bubble_ex,
    output logic             bubble_mem,
    output logic             bubble_wb,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERROR    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         init_cnt_q, init_cnt_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic mem_wait;
    logic load_use;

    assign mem_wait = mem_req_mem & ~dmem_ready;
    assign load_use = mem_read_ex & (rd_ex != 5'd0) &
                      ((rs1_used_id & (rd_ex == rs1_id)) |
                       (rs2_used_id & (rd_ex == rs2_id)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_mem   = 1'b0;
        stall_wb    = 1'b0;
        bubble_id   = 1'b0;
        bubble_ex   = 1'b0;
        bubble_mem  = 1'b0;
        bubble_wb   = 1'b0;
        mem_timeout = 1'b0;

        unique case (state_q)
            S_INIT: begin
                // Flush every pipe register while the PC is held; inputs are don't-care.
                stall_if   = 1'b1;
                bubble_id  = 1'b1;
                bubble_ex  = 1'b1;
                bubble_mem = 1'b1;
                bubble_wb  = 1'b1;
                if (init_cnt_q == 4'(INIT_CYCLES - 1)) begin
                    state_d    = S_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end

            S_RUN, S_MEM_WAIT: begin
                if (mem_wait) begin
                    // Freeze IF..MEM and drain a NOP into WB. Because EX is held,
                    // any branch there is seen again once the wait releases.
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    stall_mem = 1'b1;
                    bubble_wb = 1'b1;
                end else if (branch_taken_ex) begin
                    // The ID instruction is flushed, so a load-use hazard on it is moot.
                    bubble_id = 1'b1;
                    bubble_ex = 1'b1;
                    if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end else if (load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end

                if (stall_if && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);

                // The RUN cycle that first sees the wait counts as wait cycle 1. The
                // timeout therefore fires after MEM_TIMEOUT consecutive wait cycles.
                if (state_q == S_RUN) begin
                    if (mem_wait) begin
                        state_d    = S_MEM_WAIT;
                        wait_cnt_d = 8'd1;
                    end
                end else if (!mem_wait) begin
                    // Covers both dmem_ready and the request being withdrawn.
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == 8'(MEM_TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            S_ERROR: begin
                stall_if    = 1'b1;
                stall_id    = 1'b1;
                stall_ex    = 1'b1;
                stall_mem   = 1'b1;
                stall_wb    = 1'b1;
                mem_timeout = 1'b1;
            end

            default: state_d = S_INIT;
        endcase
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline controller for the 5-stage RV32 core.
- Generates the per-stage stall and bubble controls consumed by the pipe registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC stall.
- Sequences three things: post-reset pipeline flush, load-use interlock, and data-memory wait with timeout.
- Also keeps saturating stall and flush counters for performance monitoring.

Parameters:
INIT_CYCLES, 4, cycles of forced all-stage bubble after reset release (1..15)
MEM_TIMEOUT, 16, consecutive dmem wait cycles before entering ERROR (2..255)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs1_id, rs2_id  in  5 each  source registers of the instruction in ID
rs1_used_id, rs2_used_id  in  1 each  source actually read by the ID instruction
rd_ex  in  5  destination of the instruction in EX
mem_read_ex  in  1  EX instruction is a load
branch_taken_ex  in  1  EX resolved a taken branch or jump (redirect)
mem_req_mem  in  1  MEM instruction accesses dmem (mem_read_mem | mem_write_mem)
dmem_ready  in  1  dmem completes the access this cycle
stall_if  out  1  hold PC
stall_id, stall_ex, stall_mem, stall_wb  out  1 each  hold the named pipe register
bubble_id, bubble_ex, bubble_mem, bubble_wb  out  1 each  load default (NOP) into the named pipe register
mem_timeout  out  1  sticky error flag
stall_cnt  out  CNT_W  cycles with stall_if=1 in RUN/MEM_WAIT
flush_cnt  out  CNT_W  number of branch redirects taken

Behaviour:
- Pipe register semantics:
  - stall holds the register contents.
  - bubble loads the default value.
  - For any stage, this block never asserts stall and bubble together.
- FSM states are INIT, RUN, MEM_WAIT and ERROR. Reset forces INIT, init_cnt=0, wait_cnt=0, counters=0 and mem_timeout=0.
- INIT:
  - stall_if=1; bubble_id/ex/mem/wb=1; all stall_x=0.
  - init_cnt increments each cycle; the FSM moves to RUN after INIT_CYCLES cycles.
  - Inputs are ignored.
- Outputs in RUN and MEM_WAIT are combinational from the inputs, evaluated in priority order:
  1. mem_wait = mem_req_mem & ~dmem_ready.
     - Outputs: stall_if, stall_id, stall_ex, stall_mem = 1; bubble_wb=1.
     - The branch and load-use terms are suppressed; the EX instruction is held, so branch_taken_ex re-presents after release.
  2. branch_taken_ex.
     - Outputs: bubble_id=1, bubble_ex=1; no stalls.
     - flush_cnt++ (saturating).
     - A simultaneous load-use is ignored because the ID instruction is flushed.
  3. load_use = mem_read_ex & (rd_ex!=0) & ((rs1_used_id & rd_ex==rs1_id) | (rs2_used_id & rd_ex==rs2_id)).
     - Outputs: stall_if=1, stall_id=1, bubble_ex=1.
  4. Otherwise all outputs are 0.
- Transitions and counters:
  - RUN→MEM_WAIT when mem_wait; wait_cnt is set to 1.
  - MEM_WAIT:
    - If dmem_ready=1: that cycle releases (rule 2/3/4 apply); next state RUN; wait_cnt=0.
    - Else wait_cnt++.
    - If wait_cnt reaches MEM_TIMEOUT-1 with dmem_ready still 0: next state ERROR.
  - mem_req_mem dropping to 0 during MEM_WAIT counts as release and returns to RUN.
- ERROR:
  - stall_if and all stall_x=1; all bubbles=0; mem_timeout=1.
  - Left only by reset.
- stall_cnt:
  - Increments on every RUN/MEM_WAIT cycle with stall_if=1.
  - Both counters saturate at all-ones.
- Reset asserted mid-operation: all state clears immediately (async) and the FSM restarts INIT.
- Reset values of outputs (INIT):
  - stall_if=1; bubble_id/ex/mem/wb=1.
  - stall_id/ex/mem/wb=0.
  - mem_timeout=0; stall_cnt=0; flush_cnt=0.

Test Plan:
- Reset release with idle inputs → bubble_id..wb=1 and stall_if=1 for exactly 4 cycles, then all outputs 0; counters remain 0.
- Load-use: mem_read_ex=1, rd_ex=5, rs2_id=5, rs2_used_id=1 for one cycle → stall_if=stall_id=bubble_ex=1 that cycle; stall_cnt=1. Same with rd_ex=0 → no stall.
- Branch plus load-use together: branch_taken_ex=1 with load-use condition true → only bubble_id=bubble_ex=1; flush_cnt=1; stall_cnt unchanged.
- Memory wait: mem_req_mem=1, dmem_ready=0 for 3 cycles then 1 → stall_if/id/ex/mem=1 and bubble_wb=1 for 3 cycles; 4th cycle outputs 0; state back to RUN; stall_cnt=3.
- Timeout: mem_req_mem=1, dmem_ready=0 held 20 cycles → ERROR entered after 16 wait cycles; mem_timeout=1 and all stalls=1 persist; dmem_ready=1 afterward has no effect; rst_n low clears to INIT.
- Async reset during MEM_WAIT (cycle 2 of wait) → outputs immediately take INIT values without waiting for a clock edge; counters=0.
